// File: rtl/unidad_control_if.sv
// Control bus between the multicycle control unit and its datapath.
interface unidad_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       pc_we;
    logic       ir_we;
    logic       alu_out_we;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       addr_sel;
    logic       pc_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] wb_sel;
    logic [3:0] alu_sel;
    logic       illegal;

    // Control unit side: decodes instruction fields, drives enables and selects.
    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output pc_we, ir_we, alu_out_we, reg_we, mem_re, mem_we, addr_sel, pc_sel,
               alu_a_sel, alu_b_sel, wb_sel, alu_sel, illegal
    );

    // Datapath side.
    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  pc_we, ir_we, alu_out_we, reg_we, mem_re, mem_we, addr_sel, pc_sel,
               alu_a_sel, alu_b_sel, wb_sel, alu_sel, illegal
    );
endinterface

// File: rtl/unidad_control.sv
// Multicycle RV32I control unit: Moore FSM driving datapath enables and selects.
module unidad_control (
    input  logic              clk,
    input  logic              rst,
    unidad_control_if.master  bus
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StExecU, StAddr, StMemRd,
        StMemWr, StWbAlu, StWbMem, StBranch, StJal, StJalr, StTrap
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    state_e state_q, state_d;

    logic branch_ok;
    logic branch_taken;

    // funct3 010/011 are not branch encodings.
    assign branch_ok = (bus.funct3[2:1] != 2'b01);
    // eq/ge-style (ge, geu) take on zero=1; ne/lt-style take on zero=0.
    assign branch_taken = bus.funct3[2] ? (bus.zero == bus.funct3[0])
                                        : (bus.zero != bus.funct3[0]);

    // State register with asynchronous return to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.op)
                    OpR:              state_d = StExecR;
                    OpI:              state_d = StExecI;
                    OpLui, OpAuipc:   state_d = StExecU;
                    OpLoad, OpStore:  state_d = StAddr;
                    OpBranch:         state_d = StBranch;
                    OpJal:            state_d = StJal;
                    OpJalr:           state_d = StJalr;
                    default:          state_d = StTrap;
                endcase
            end
            StExecR, StExecI, StExecU: state_d = StWbAlu;
            StAddr:   state_d = (bus.op == OpLoad) ? StMemRd : StMemWr;
            StMemRd:  if (bus.mem_ready) state_d = StWbMem;
            StMemWr:  if (bus.mem_ready) state_d = StFetch;
            StWbAlu, StWbMem, StJal, StJalr: state_d = StFetch;
            StBranch: state_d = branch_ok ? StFetch : StTrap;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        bus.pc_we      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.alu_out_we = 1'b0;
        bus.reg_we     = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.pc_sel     = 1'b0;
        bus.alu_a_sel  = 2'b00;
        bus.alu_b_sel  = 2'b00;
        bus.wb_sel     = 2'b00;
        bus.alu_sel    = 4'b0000;
        bus.illegal    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    bus.mem_re    = 1'b1;
                    bus.alu_a_sel = 2'b01;
                    bus.alu_b_sel = 2'b10;
                    // Commit IR and PC+4 only on the cycle the fetch completes.
                    bus.ir_we     = bus.mem_ready;
                    bus.pc_we     = bus.mem_ready;
                end
                StDecode: begin
                    // Precompute the branch/jump target pc_old + imm.
                    bus.alu_a_sel  = 2'b10;
                    bus.alu_b_sel  = 2'b01;
                    bus.alu_out_we = 1'b1;
                end
                StExecR: begin
                    bus.alu_sel    = {bus.funct3, bus.funct7_5};
                    bus.alu_out_we = 1'b1;
                end
                StExecI: begin
                    bus.alu_b_sel  = 2'b01;
                    // Only shift-right immediates carry a meaningful funct7 bit.
                    bus.alu_sel    = {bus.funct3, (bus.funct3 == 3'b101) & bus.funct7_5};
                    bus.alu_out_we = 1'b1;
                end
                StExecU: begin
                    bus.alu_a_sel  = (bus.op == OpLui) ? 2'b11 : 2'b10;
                    bus.alu_b_sel  = 2'b01;
                    bus.alu_out_we = 1'b1;
                end
                StAddr: begin
                    bus.alu_b_sel  = 2'b01;
                    bus.alu_out_we = 1'b1;
                end
                StMemRd: begin
                    bus.mem_re   = 1'b1;
                    bus.addr_sel = 1'b1;
                end
                StMemWr: begin
                    bus.mem_we   = 1'b1;
                    bus.addr_sel = 1'b1;
                end
                StWbAlu: bus.reg_we = 1'b1;
                StWbMem: begin
                    bus.reg_we = 1'b1;
                    bus.wb_sel = 2'b01;
                end
                StBranch: begin
                    case (bus.funct3[2:1])
                        2'b00:   bus.alu_sel = 4'b0001;
                        2'b10:   bus.alu_sel = 4'b0100;
                        2'b11:   bus.alu_sel = 4'b0110;
                        default: bus.alu_sel = 4'b0000;
                    endcase
                    bus.pc_we  = branch_ok & branch_taken;
                    bus.pc_sel = branch_ok & branch_taken;
                end
                StJal: begin
                    bus.reg_we = 1'b1;
                    bus.wb_sel = 2'b10;
                    bus.pc_we  = 1'b1;
                    bus.pc_sel = 1'b1;
                end
                StJalr: begin
                    bus.alu_b_sel = 2'b01;
                    bus.pc_we     = 1'b1;
                    bus.reg_we    = 1'b1;
                    bus.wb_sel    = 2'b10;
                end
                StTrap:  bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: phase-level reference model plus directed instruction runs.
module tb_unidad_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    string phase;

    unidad_control_if bus ();

    unidad_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: pc_we ir_we alu_out_we reg_we mem_re mem_we addr_sel pc_sel a b wb alu ill
    logic [18:0] dut_vec;
    assign dut_vec = {bus.pc_we, bus.ir_we, bus.alu_out_we, bus.reg_we, bus.mem_re,
                      bus.mem_we, bus.addr_sel, bus.pc_sel, bus.alu_a_sel, bus.alu_b_sel,
                      bus.wb_sel, bus.alu_sel, bus.illegal};

    function automatic string model_next(string ph, logic [6:0] op, logic [2:0] f3, logic rdy);
        if (ph == "FETCH")  return rdy ? "DECODE" : "FETCH";
        if (ph == "DECODE") begin
            if (op == OP_R) return "EXEC_R";
            if (op == OP_I) return "EXEC_I";
            if (op == OP_LUI || op == OP_AUI) return "EXEC_U";
            if (op == OP_LD || op == OP_ST) return "ADDR";
            if (op == OP_BR) return "BRANCH";
            if (op == OP_JAL) return "JAL";
            if (op == OP_JR) return "JALR";
            return "TRAP";
        end
        if (ph == "EXEC_R" || ph == "EXEC_I" || ph == "EXEC_U") return "WB_ALU";
        if (ph == "ADDR")   return (op == OP_LD) ? "MEM_RD" : "MEM_WR";
        if (ph == "MEM_RD") return rdy ? "WB_MEM" : "MEM_RD";
        if (ph == "MEM_WR") return rdy ? "FETCH" : "MEM_WR";
        if (ph == "BRANCH") return (f3 == 3'b010 || f3 == 3'b011) ? "TRAP" : "FETCH";
        if (ph == "TRAP")   return "TRAP";
        return "FETCH";
    endfunction

    function automatic logic [18:0] model_out(string ph, logic [6:0] op, logic [2:0] f3,
                                              logic f7, logic z, logic rdy, logic r);
        logic pcw, irw, aow, rgw, mre, mwe, asel, psel, ill, taken;
        logic [1:0] a, b, wb;
        logic [3:0] alu;
        {pcw, irw, aow, rgw, mre, mwe, asel, psel, ill} = '0;
        a = 2'd0; b = 2'd0; wb = 2'd0; alu = 4'd0; taken = 1'b0;
        if (!r) begin
            if (ph == "FETCH") begin
                mre = 1; a = 2'd1; b = 2'd2; irw = rdy; pcw = rdy;
            end else if (ph == "DECODE") begin
                a = 2'd2; b = 2'd1; aow = 1;
            end else if (ph == "EXEC_R") begin
                alu = {f3, f7}; aow = 1;
            end else if (ph == "EXEC_I") begin
                b = 2'd1; aow = 1; alu = {f3, (f3 == 3'b101) ? f7 : 1'b0};
            end else if (ph == "EXEC_U") begin
                b = 2'd1; aow = 1; a = (op == OP_LUI) ? 2'd3 : 2'd2;
            end else if (ph == "ADDR") begin
                b = 2'd1; aow = 1;
            end else if (ph == "MEM_RD") begin
                mre = 1; asel = 1;
            end else if (ph == "MEM_WR") begin
                mwe = 1; asel = 1;
            end else if (ph == "WB_ALU") begin
                rgw = 1;
            end else if (ph == "WB_MEM") begin
                rgw = 1; wb = 2'd1;
            end else if (ph == "BRANCH") begin
                case (f3)
                    3'b000: begin alu = 4'b0001; taken = z;  end
                    3'b001: begin alu = 4'b0001; taken = !z; end
                    3'b100: begin alu = 4'b0100; taken = !z; end
                    3'b101: begin alu = 4'b0100; taken = z;  end
                    3'b110: begin alu = 4'b0110; taken = !z; end
                    3'b111: begin alu = 4'b0110; taken = z;  end
                    default: ;
                endcase
                pcw = taken; psel = taken;
            end else if (ph == "JAL") begin
                rgw = 1; wb = 2'd2; pcw = 1; psel = 1;
            end else if (ph == "JALR") begin
                b = 2'd1; pcw = 1; rgw = 1; wb = 2'd2;
            end else if (ph == "TRAP") begin
                ill = 1;
            end
        end
        return {pcw, irw, aow, rgw, mre, mwe, asel, psel, a, b, wb, alu, ill};
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference phase tracker.
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= "FETCH";
        else     phase <= model_next(phase, bus.op, bus.funct3, bus.mem_ready);
    end

    // Per-cycle comparison; operand selects are don't-care while a fetch is still waiting.
    always @(negedge clk) begin
        logic [18:0] mask;
        mask = '1;
        if (phase == "FETCH" && !bus.mem_ready) mask = ~19'h00780;
        check({"cycle ", phase}, dut_vec & mask,
              model_out(phase, bus.op, bus.funct3, bus.funct7_5, bus.zero,
                        bus.mem_ready, rst) & mask);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input logic rdy);
        bus.op = op; bus.funct3 = f3; bus.funct7_5 = f7; bus.zero = z; bus.mem_ready = rdy;
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int n);
        set_in(op, f3, f7, z, 1'b1);
        repeat (n) tick();
    endtask

    logic [2:0] br_f3 [10] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100,
                               3'b100, 3'b110, 3'b110, 3'b111, 3'b111};
    logic       br_z  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        phase    = "FETCH";
        rst      = 1'b1;
        set_in(7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        lit("reset mem_re", int'(bus.mem_re), 0);
        lit("reset illegal", int'(bus.illegal), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        look();
        lit("fetch wait mem_re", int'(bus.mem_re), 1);
        lit("fetch wait ir_we", int'(bus.ir_we), 0);

        // add x3,x1,x2
        set_in(OP_R, 3'b000, 1'b0, 1'b0, 1'b1);
        #1;
        lit("add fetch ir_we", int'(bus.ir_we), 1);
        lit("add fetch pc_we", int'(bus.pc_we), 1);
        tick(); look();
        lit("add decode alu_out_we", int'(bus.alu_out_we), 1);
        lit("add decode a_sel", int'(bus.alu_a_sel), 2);
        tick(); look();
        lit("add exec alu_sel", int'(bus.alu_sel), 0);
        lit("add exec reg_we", int'(bus.reg_we), 0);
        tick(); look();
        lit("add wb reg_we", int'(bus.reg_we), 1);
        tick(); look();
        lit("add back fetch reg_we", int'(bus.reg_we), 0);
        lit("add back fetch mem_re", int'(bus.mem_re), 1);

        run(OP_R, 3'b000, 1'b1, 1'b0, 4);  // sub
        run(OP_R, 3'b101, 1'b1, 1'b0, 4);  // sra

        // srai then addi with stray funct7_5
        set_in(OP_I, 3'b101, 1'b1, 1'b0, 1'b1);
        tick(); tick(); look();
        lit("srai alu_sel", int'(bus.alu_sel), 11);
        tick(); tick();
        set_in(OP_I, 3'b000, 1'b1, 1'b0, 1'b1);
        tick(); tick(); look();
        lit("addi alu_sel", int'(bus.alu_sel), 0);
        tick(); tick();
        run(OP_I, 3'b010, 1'b0, 1'b0, 4);

        set_in(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(); tick(); look();
        lit("lui a_sel", int'(bus.alu_a_sel), 3);
        tick(); tick();
        run(OP_AUI, 3'b011, 1'b0, 1'b0, 4);

        // lw with three wait cycles
        set_in(OP_LD, 3'b010, 1'b0, 1'b0, 1'b1);
        tick();
        bus.mem_ready = 1'b0;
        tick(); tick(); look();
        lit("lw rd1 mem_re", int'(bus.mem_re), 1);
        lit("lw rd1 addr_sel", int'(bus.addr_sel), 1);
        tick(); look();
        lit("lw rd2 mem_re", int'(bus.mem_re), 1);
        tick(); look();
        lit("lw rd3 mem_re", int'(bus.mem_re), 1);
        tick();
        bus.mem_ready = 1'b1;
        look();
        lit("lw rd4 mem_re", int'(bus.mem_re), 1);
        tick(); look();
        lit("lw wb_sel", int'(bus.wb_sel), 1);
        lit("lw wb reg_we", int'(bus.reg_we), 1);
        lit("lw wb mem_re", int'(bus.mem_re), 0);
        tick();

        run(OP_ST, 3'b010, 1'b0, 1'b0, 4);

        // sw interrupted by reset while waiting
        set_in(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1);
        tick();
        bus.mem_ready = 1'b0;
        tick(); tick(); look();
        lit("sw wait mem_we", int'(bus.mem_we), 1);
        rst = 1'b1;
        #1;
        lit("sw reset mem_we", int'(bus.mem_we), 0);
        lit("sw reset reg_we", int'(bus.reg_we), 0);
        tick();
        rst = 1'b0;
        look();
        lit("sw release mem_re", int'(bus.mem_re), 1);
        lit("sw release mem_we", int'(bus.mem_we), 0);

        // bge taken / not taken
        set_in(OP_BR, 3'b101, 1'b0, 1'b1, 1'b1);
        tick(); tick(); look();
        lit("bge taken pc_we", int'(bus.pc_we), 1);
        lit("bge taken pc_sel", int'(bus.pc_sel), 1);
        lit("bge alu_sel", int'(bus.alu_sel), 4);
        tick(); look();
        lit("bge taken next fetch", int'(bus.mem_re), 1);
        set_in(OP_BR, 3'b101, 1'b0, 1'b0, 1'b1);
        tick(); tick(); look();
        lit("bge not taken pc_we", int'(bus.pc_we), 0);
        tick(); look();
        lit("bge not taken next fetch", int'(bus.mem_re), 1);
        for (int i = 0; i < 10; i++) run(OP_BR, br_f3[i], 1'b0, br_z[i], 3);

        run(OP_JAL, 3'b000, 1'b0, 1'b0, 3);
        set_in(OP_JR, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(); tick(); look();
        lit("jalr wb_sel", int'(bus.wb_sel), 2);
        lit("jalr pc_sel", int'(bus.pc_sel), 0);
        tick();

        // branch with funct3=010 traps
        set_in(OP_BR, 3'b010, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick(); look();
        lit("bad branch illegal", int'(bus.illegal), 1);
        rst = 1'b1;
        #1;
        lit("bad branch reset illegal", int'(bus.illegal), 0);
        tick();
        rst = 1'b0;

        // undefined opcode traps and stays trapped
        set_in(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            look();
            lit("trap illegal held", int'(bus.illegal), 1);
            lit("trap pc_we", int'(bus.pc_we), 0);
            tick();
        end
        rst = 1'b1;
        #1;
        lit("trap reset illegal", int'(bus.illegal), 0);
        lit("trap reset mem_re", int'(bus.mem_re), 0);
        tick();
        rst = 1'b0;
        look();
        lit("trap release illegal", int'(bus.illegal), 0);
        lit("trap release mem_re", int'(bus.mem_re), 1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
